// File: rtl/core_pkg.sv
// ============================================================================
// Module : core (package)
// Brief  : Shared types for the core memory path (requester identifiers).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core;

  typedef enum logic {
    PORT_INST = 1'b0,
    PORT_DATA = 1'b1
  } port_t;

endpackage

`default_nettype wire

// File: rtl/axi_if.sv
// ============================================================================
// Module : axi (interface)
// Brief  : AXI4 read-channel subset (AR and R) with master/slave modports.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

`default_nettype wire

// File: rtl/owner_fifo.sv
// ============================================================================
// Module : owner_fifo
// Brief  : Synchronous FIFO of requester identifiers recording who owns each
//          outstanding downstream read, oldest at the head.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module owner_fifo
  import core::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  aclk,
  input  logic  aresetn,
  input  logic  push,
  input  port_t push_port,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output port_t head
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  port_t         mem_q [DEPTH];
  port_t         mem_d [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  // Fullness is judged on the start-of-cycle count; a same-cycle pop never frees a slot.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_port;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= PORT_INST;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Brief  : Shares one AXI4 read port between instruction fetch and load unit;
//          routes in-order R responses back through an owner FIFO.
//          Define ARBITER_RR_EN for round-robin, otherwise data has fixed
//          priority over inst.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import core::*;
#(
  parameter int DEPTH = 4
) (
  input  logic aclk,
  input  logic aresetn,
  axi.slave    inst,
  axi.slave    data,
  axi.master   cache
);

  logic  fifo_full;
  logic  fifo_empty;
  port_t head;

  logic  lock_q, lock_d;
  port_t lock_owner_q, lock_owner_d;
  port_t prio;
  port_t sel;
  logic  sel_valid;
  logic  ar_open;
  logic  ar_valid;
  logic  ar_hs;
  logic  r_active;
  logic  owner_rready;
  logic  r_ready;
  logic  r_hs;

`ifdef ARBITER_RR_EN
  port_t rr_q, rr_d;

  // Priority flips to whichever requester was not just served.
  always_comb begin
    rr_d = rr_q;
    if (ar_hs) begin
      rr_d = (sel == PORT_DATA) ? PORT_INST : PORT_DATA;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_q <= PORT_DATA;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign prio = rr_q;
`else
  assign prio = PORT_DATA;
`endif

  always_comb begin
    sel = PORT_INST;
    if (lock_q) begin
      sel = lock_owner_q;
    end else if (inst.arvalid && data.arvalid) begin
      sel = prio;
    end else if (data.arvalid) begin
      sel = PORT_DATA;
    end
  end

  assign sel_valid     = (sel == PORT_DATA) ? data.arvalid : inst.arvalid;
  assign ar_open       = aresetn & ~fifo_full;
  assign ar_valid      = ar_open & sel_valid;
  assign ar_hs         = ar_valid & cache.arready;

  assign cache.arvalid = ar_valid;
  assign cache.araddr  = (sel == PORT_DATA) ? data.araddr : inst.araddr;
  assign cache.arprot  = (sel == PORT_DATA) ? data.arprot : inst.arprot;
  assign inst.arready  = ar_open & (sel == PORT_INST) & cache.arready;
  assign data.arready  = ar_open & (sel == PORT_DATA) & cache.arready;

  // A presented-but-stalled AR pins the owner so the downstream address stays stable.
  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    if (ar_hs) begin
      lock_d = 1'b0;
    end else if (ar_valid) begin
      lock_d       = 1'b1;
      lock_owner_d = sel;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lock_q       <= 1'b0;
      lock_owner_q <= PORT_INST;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
    end
  end

  assign r_active     = aresetn & ~fifo_empty;
  assign owner_rready = (head == PORT_DATA) ? data.rready : inst.rready;
  assign r_ready      = r_active & owner_rready;
  assign r_hs         = cache.rvalid & r_ready;

  assign cache.rready = r_ready;
  assign inst.rvalid  = r_active & (head == PORT_INST) & cache.rvalid;
  assign data.rvalid  = r_active & (head == PORT_DATA) & cache.rvalid;
  assign inst.rdata   = cache.rdata;
  assign data.rdata   = cache.rdata;
  assign inst.rresp   = cache.rresp;
  assign data.rresp   = cache.rresp;

  owner_fifo #(
    .DEPTH (DEPTH)
  ) u_owner_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (ar_hs),
    .push_port (sel),
    .pop       (r_hs),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

endmodule

`default_nettype wire
